wb_sram_ctrl: RTL

WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

---
 rtl/wb_sram_pkg.sv | 13 +
 rtl/wb_if.sv | 25 ++
 rtl/wb_sram_mem.sv | 26 ++
 rtl/wb_sram_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/wb_sram_pkg.sv
// Shared types and helpers for the Wishbone SRAM controller.
package wb_sram_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   function automatic int idx_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle with master and slave views.
interface wb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   adr;
   logic [DATA_W-1:0]   dat_w;
   logic [DATA_W-1:0]   dat_r;
   logic                cyc;
   logic                stb;
   logic                we;
   logic [DATA_W/8-1:0] sel;
   logic                ack;
   logic                err;

   modport slave (
      input  adr, dat_w, cyc, stb, we, sel,
      output dat_r, ack, err
   );

   modport master (
      output adr, dat_w, cyc, stb, we, sel,
      input  dat_r, ack, err
   );
endinterface

// File: rtl/wb_sram_mem.sv
// Single-port synchronous RAM with byte-lane write enables and registered read data.
module wb_sram_mem #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   // Read-before-write: rdata returns the word as it was before this edge's write.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone slave front end for an on-chip SRAM: address decode, 2-state FSM, ACK/ERR generation.
module wb_sram_ctrl
   import wb_sram_pkg::*;
#(
   parameter int                       WB_ADDR_WIDTH   = 32,
   parameter int                       WB_DATA_WIDTH   = 32,
   parameter logic [WB_ADDR_WIDTH-1:0] MEM_BASE        = 'h1000_0000,
   parameter int                       MEM_DEPTH_WORDS = 1024
) (
   input logic clk,
   input logic rst,
   wb_if.slave s
);

   localparam int IDX_W = idx_width(MEM_DEPTH_WORDS);
   localparam logic [WB_ADDR_WIDTH:0] SPAN = (WB_ADDR_WIDTH + 1)'(4 * MEM_DEPTH_WORDS);

   state_t                     state, state_d;
   logic                       accept;
   logic                       in_range;
   logic [WB_ADDR_WIDTH-1:0]   off;
   logic [IDX_W-1:0]           idx;
   logic                       mem_en;
   logic [3:0]                 mem_we;
   logic [31:0]                rdata;
   logic                       hit_q;
   logic                       rd_q;
   logic [WB_DATA_WIDTH-1:0]   dat_q;

   // Both bounds checked on the unsigned offset; the lower bound guards the wrap below MEM_BASE.
   assign off      = s.adr - MEM_BASE;
   assign in_range = (s.adr >= MEM_BASE) && ({1'b0, off} < SPAN);
   assign idx      = off[IDX_W+1:2];

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      case (state)
         IDLE: begin
            if (s.cyc && s.stb) begin
               accept  = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_en = accept && in_range;
   assign mem_we = (mem_en && s.we) ? s.sel : 4'b0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hit_q <= 1'b0;
         rd_q  <= 1'b0;
         dat_q <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            hit_q <= in_range;
            rd_q  <= !s.we;
         end
         if (state == RESP && hit_q && rd_q) dat_q <= rdata;
      end
   end

   wb_sram_mem #(
      .DEPTH  (MEM_DEPTH_WORDS),
      .ADDR_W (IDX_W)
   ) u_mem (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (idx),
      .wdata (s.dat_w),
      .rdata (rdata)
   );

   // Fresh read data is forwarded during RESP; otherwise the last read word is held.
   assign s.ack   = (state == RESP) && hit_q;
   assign s.err   = (state == RESP) && !hit_q;
   assign s.dat_r = (state == RESP && hit_q && rd_q) ? rdata : dat_q;

endmodule
